// File: rtl/data_mem_responder_if.sv
// Load/store bus between the MEM stage and a slow data memory.
// master = pipeline side, slave = memory responder side.
interface data_mem_responder_if;
   logic        rd_en;
   logic        wr_en;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        ready;
   logic        addr_err;

   modport master (
      output rd_en,
      output wr_en,
      output address,
      output write_data,
      input  read_data,
      input  ready,
      input  addr_err
   );

   modport slave (
      input  rd_en,
      input  wr_en,
      input  address,
      input  write_data,
      output read_data,
      output ready,
      output addr_err
   );
endinterface

// File: rtl/data_mem_responder.sv
// Wait-state data memory responder for the MEM stage.
// Latches a request, waits WAIT_CYCLES, then completes it.
module data_mem_responder #(
   parameter int          DEPTH       = 64,
   parameter int          WAIT_CYCLES = 4,
   parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
   input  logic                 clk,
   input  logic                 rst,
   data_mem_responder_if.slave  bus
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0]  CNT_INIT = 4'(WAIT_CYCLES - 1);
   localparam logic [29:0] DEPTH_W  = 30'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE
   } state_t;

   state_t                     state_q;
   logic [3:0]                 cnt_q;
   logic [31:0]                addr_q;
   logic [31:0]                wdata_q;
   logic                       wr_q;
   logic [DEPTH-1:0][31:0]     mem_q;
   logic [31:0]                rdata_q;
   logic                       err_q;

   logic                       req;
   logic [31:0]                offset;
   logic [29:0]                idx;
   logic [AW-1:0]              widx;
   logic                       oor;
   logic                       unused_lsb;

   assign req        = bus.rd_en | bus.wr_en;
   assign offset     = addr_q - BASE_ADDR;
   assign idx        = offset[31:2];
   assign unused_lsb = ^offset[1:0];
   assign widx       = idx[AW-1:0];
   assign oor        = (addr_q < BASE_ADDR) | (idx >= DEPTH_W);

   // ready: combinational in IDLE so an absent request never stalls
   assign bus.ready     = (state_q == IDLE) ? ~req : (state_q == DONE);
   assign bus.read_data = rdata_q;
   assign bus.addr_err  = err_q;

   // Request FSM, wait counter, array and registered responses
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
         mem_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         err_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (req) begin
                  addr_q  <= bus.address;
                  wdata_q <= bus.write_data;
                  wr_q    <= bus.wr_en;
                  cnt_q   <= CNT_INIT;
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               if (cnt_q == 4'd0) begin
                  state_q <= DONE;
                  if (oor) begin
                     rdata_q <= '0;
                     err_q   <= 1'b1;
                  end else if (wr_q) begin
                     mem_q[widx] <= wdata_q;
                     rdata_q     <= wdata_q;
                  end else begin
                     rdata_q <= mem_q[widx];
                  end
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios plus random
// traffic checked against an address-level memory model.
module tb_data_mem_responder;

   localparam int          DEPTH = 64;
   localparam int          WC    = 4;
   localparam logic [31:0] BASE  = 32'd1024;
   localparam int          LAT   = WC + 1;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_fail;

   logic [31:0] ref_mem [DEPTH];

   data_mem_responder_if bus();

   data_mem_responder #(
      .DEPTH(DEPTH),
      .WAIT_CYCLES(WC),
      .BASE_ADDR(BASE)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void model_clear();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
   endfunction

   // write wins when both enables are set
   function automatic void model_access(
      input  logic        wr,
      input  logic [31:0] a,
      input  logic [31:0] wd,
      output logic [31:0] ed,
      output logic        ee
   );
      longint unsigned ia;
      longint unsigned k;
      ia = longint'(a);
      if (ia < longint'(BASE)) begin
         ed = '0;
         ee = 1'b1;
      end else begin
         k = (ia - longint'(BASE)) / 4;
         if (k >= DEPTH) begin
            ed = '0;
            ee = 1'b1;
         end else begin
            ee = 1'b0;
            if (wr) ref_mem[k] = wd;
            ed = ref_mem[k];
         end
      end
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      bus.rd_en = 1'b0;
      bus.wr_en = 1'b0;
      bus.address = '0;
      bus.write_data = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      model_clear();
   endtask

   // Starts at posedge+1, returns at posedge+1 after DONE
   task automatic run_access(
      input  logic        rd,
      input  logic        wr,
      input  logic [31:0] a,
      input  logic [31:0] wd,
      input  bit          hold,
      input  bit          keep,
      output int          lat,
      output logic [31:0] rdata,
      output logic        err
   );
      bus.rd_en = rd;
      bus.wr_en = wr;
      bus.address = a;
      bus.write_data = wd;
      lat = -1;
      rdata = 'x;
      err = 1'bx;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (c > 0 && bus.ready === 1'b1) begin
            lat = c;
            rdata = bus.read_data;
            err = bus.addr_err;
            break;
         end
         @(posedge clk);
         #1;
         if (!hold) begin
            bus.rd_en = 1'b0;
            bus.wr_en = 1'b0;
            bus.address = $urandom;
            bus.write_data = $urandom;
         end
      end
      @(posedge clk);
      #1;
      if (!keep) begin
         bus.rd_en = 1'b0;
         bus.wr_en = 1'b0;
      end
   endtask

   task automatic test_reset();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_cmp += 3;
         if (bus.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_ready c%0d got %b exp 1", i, bus.ready);
         end
         if (bus.read_data !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_rdata c%0d got %h exp 0",
                     i, bus.read_data);
         end
         if (bus.addr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_err c%0d got %b exp 0", i, bus.addr_err);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_write_read();
      int          lat;
      logic [31:0] rd;
      logic        er;
      logic [31:0] ed;
      logic        ee;
      logic [31:0] av [3];
      logic        wv [3];
      av[0] = 32'd1028; wv[0] = 1'b1;
      av[1] = 32'd1028; wv[1] = 1'b0;
      av[2] = 32'd1031; wv[2] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         run_access(~wv[i], wv[i], av[i], 32'hDEADBEEF,
                    1'b1, 1'b0, lat, rd, er);
         model_access(wv[i], av[i], 32'hDEADBEEF, ed, ee);
         n_cmp += 4;
         if (lat !== LAT) begin
            n_fail++;
            $display("FAIL wr_lat i%0d got %0d exp %0d", i, lat, LAT);
         end
         if (rd !== ed) begin
            n_fail++;
            $display("FAIL wr_data i%0d got %h exp %h", i, rd, ed);
         end
         if (rd !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL wr_const i%0d got %h exp deadbeef", i, rd);
         end
         if (er !== ee) begin
            n_fail++;
            $display("FAIL wr_err i%0d got %b exp %b", i, er, ee);
         end
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp += 2;
         if (bus.read_data !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL hold_rdata c%0d got %h exp deadbeef",
                     i, bus.read_data);
         end
         if (bus.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_ready c%0d got %b exp 1", i, bus.ready);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_bounds();
      int          lat;
      logic [31:0] rd;
      logic        er;
      logic [31:0] ed;
      logic        ee;
      logic [31:0] av [4];
      logic        wv [4];
      av[0] = 32'd1020; wv[0] = 1'b1;
      av[1] = 32'd1280; wv[1] = 1'b1;
      av[2] = 32'd1020; wv[2] = 1'b0;
      av[3] = 32'd1024; wv[3] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         run_access(~wv[i], wv[i], av[i], 32'h12345678,
                    1'b1, 1'b0, lat, rd, er);
         model_access(wv[i], av[i], 32'h12345678, ed, ee);
         n_cmp += 3;
         if (lat !== LAT) begin
            n_fail++;
            $display("FAIL bnd_lat i%0d got %0d exp %0d", i, lat, LAT);
         end
         if (rd !== ed) begin
            n_fail++;
            $display("FAIL bnd_data i%0d got %h exp %h", i, rd, ed);
         end
         if (er !== ee) begin
            n_fail++;
            $display("FAIL bnd_err i%0d got %b exp %b", i, er, ee);
         end
         @(negedge clk);
         n_cmp++;
         if (bus.addr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL bnd_pulse i%0d got %b exp 0", i, bus.addr_err);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset_mid();
      int          lat;
      logic [31:0] rd;
      logic        er;
      logic [31:0] ed;
      logic        ee;
      bus.wr_en = 1'b1;
      bus.address = 32'd1032;
      bus.write_data = 32'hCAFEF00D;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      bus.wr_en = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      model_clear();
      @(negedge clk);
      n_cmp += 3;
      if (bus.ready !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_ready got %b exp 1", bus.ready);
      end
      if (bus.read_data !== 32'h0) begin
         n_fail++;
         $display("FAIL mid_rdata got %h exp 0", bus.read_data);
      end
      if (bus.addr_err !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_err got %b exp 0", bus.addr_err);
      end
      @(posedge clk);
      #1;
      run_access(1'b1, 1'b0, 32'd1032, '0, 1'b1, 1'b0, lat, rd, er);
      model_access(1'b0, 32'd1032, '0, ed, ee);
      n_cmp += 2;
      if (lat !== LAT) begin
         n_fail++;
         $display("FAIL mid_lat got %0d exp %0d", lat, LAT);
      end
      if (rd !== ed) begin
         n_fail++;
         $display("FAIL mid_read got %h exp %h", rd, ed);
      end
      run_access(1'b1, 1'b0, 32'd1028, '0, 1'b1, 1'b0, lat, rd, er);
      model_access(1'b0, 32'd1028, '0, ed, ee);
      n_cmp++;
      if (rd !== ed) begin
         n_fail++;
         $display("FAIL mid_clear got %h exp %h", rd, ed);
      end
   endtask

   task automatic test_both();
      int          lat;
      logic [31:0] rd;
      logic        er;
      logic [31:0] ed;
      logic        ee;
      run_access(1'b1, 1'b1, 32'd1036, 32'h0000A5A5,
                 1'b1, 1'b0, lat, rd, er);
      model_access(1'b1, 32'd1036, 32'h0000A5A5, ed, ee);
      n_cmp += 2;
      if (lat !== LAT) begin
         n_fail++;
         $display("FAIL both_lat got %0d exp %0d", lat, LAT);
      end
      if (rd !== ed) begin
         n_fail++;
         $display("FAIL both_data got %h exp %h", rd, ed);
      end
      run_access(1'b1, 1'b0, 32'd1036, '0, 1'b1, 1'b0, lat, rd, er);
      model_access(1'b0, 32'd1036, '0, ed, ee);
      n_cmp++;
      if (rd !== ed) begin
         n_fail++;
         $display("FAIL both_read got %h exp %h", rd, ed);
      end
   endtask

   // request held past DONE restarts immediately
   task automatic test_back_to_back();
      int          lat;
      logic [31:0] rd;
      logic        er;
      logic [31:0] ed;
      logic        ee;
      logic [31:0] a;
      logic [31:0] wd;
      for (int i = 0; i < 4; i++) begin
         a  = BASE + 4 * $urandom_range(0, DEPTH - 1);
         wd = $urandom;
         for (int j = 0; j < 2; j++) begin
            run_access(1'b0, 1'b1, a, wd, 1'b1, (j == 0),
                       lat, rd, er);
            model_access(1'b1, a, wd, ed, ee);
            n_cmp += 2;
            if (lat !== LAT) begin
               n_fail++;
               $display("FAIL b2b_lat i%0d j%0d got %0d exp %0d",
                        i, j, lat, LAT);
            end
            if (rd !== ed) begin
               n_fail++;
               $display("FAIL b2b_data i%0d j%0d got %h exp %h",
                        i, j, rd, ed);
            end
         end
         for (int j = 0; j < 2; j++) begin
            run_access(1'b1, 1'b0, a, '0, 1'b1, (j == 0),
                       lat, rd, er);
            model_access(1'b0, a, '0, ed, ee);
            n_cmp++;
            if (rd !== ed) begin
               n_fail++;
               $display("FAIL b2b_read i%0d j%0d got %h exp %h",
                        i, j, rd, ed);
            end
         end
      end
   endtask

   task automatic test_random();
      int          lat;
      logic [31:0] rd;
      logic        er;
      logic [31:0] ed;
      logic        ee;
      logic [31:0] a;
      logic [31:0] wd;
      logic        rv;
      logic        wv;
      bit          hold;
      int unsigned sel;
      for (int i = 0; i < 80; i++) begin
         sel = $urandom_range(0, 9);
         if (sel == 0) a = BASE - 32'($urandom_range(1, 64));
         else if (sel == 1) a = $urandom;
         else a = BASE + 32'($urandom_range(0, 4 * DEPTH + 15));
         wd = $urandom;
         sel = $urandom_range(0, 4);
         rv = (sel != 0) && (sel != 1);
         wv = (sel <= 1) || (sel == 4);
         hold = ($urandom_range(0, 2) != 0);
         run_access(rv, wv, a, wd, hold, 1'b0, lat, rd, er);
         model_access(wv, a, wd, ed, ee);
         n_cmp += 3;
         if (lat !== LAT) begin
            n_fail++;
            $display("FAIL rnd_lat i%0d got %0d exp %0d", i, lat, LAT);
         end
         if (rd !== ed) begin
            n_fail++;
            $display("FAIL rnd_data i%0d a=%h got %h exp %h",
                     i, a, rd, ed);
         end
         if (er !== ee) begin
            n_fail++;
            $display("FAIL rnd_err i%0d a=%h got %b exp %b",
                     i, a, er, ee);
         end
      end
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      rst = 1'b1;
      bus.rd_en = 1'b0;
      bus.wr_en = 1'b0;
      bus.address = '0;
      bus.write_data = '0;
      test_reset();
      test_write_read();
      test_bounds();
      test_reset_mid();
      test_both();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_fail);
      $finish;
   end

endmodule
